// File: rtl/output_read_pkg.sv
// ---------------------------------------------------------------------------
// output_read_pkg : output-buffer layout constants and per-layer geometry
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package output_read_pkg;

  localparam int PartWords   = 1024;
  localparam int HalfOffset  = 4096;
  localparam int RowsPerPart = 6;

  localparam logic [12:0] BaseAddrPart0 = 13'd0;
  localparam logic [12:0] BaseAddrPart1 = 13'd1024;
  localparam logic [12:0] BaseAddrPart2 = 13'd2048;
  localparam logic [12:0] BaseAddrPart3 = 13'd3072;
  localparam logic [12:0] BaseAddrPart4 = 13'd4096;
  localparam logic [12:0] BaseAddrPart5 = 13'd5120;
  localparam logic [12:0] BaseAddrPart6 = 13'd6144;
  localparam logic [12:0] BaseAddrPart7 = 13'd7168;

  localparam logic [2:0] LAYER_1 = 3'd1;
  localparam logic [2:0] LAYER_2 = 3'd2;
  localparam logic [2:0] LAYER_3 = 3'd3;
  localparam logic [2:0] LAYER_4 = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONFIG = 2'd1,
    S_READ   = 2'd2,
    S_DRAIN  = 2'd3
  } rd_state_e;

  function automatic logic [9:0] layer_w(input logic [2:0] l);
    logic [9:0] w;
    w = 10'd0;
    case (l)
      LAYER_1: w = 10'd119;
      LAYER_2: w = 10'd59;
      LAYER_3: w = 10'd29;
      LAYER_4: w = 10'd14;
      default: w = 10'd0;
    endcase
    return w;
  endfunction

  function automatic logic layer_legal(input logic [2:0] l);
    return (l >= LAYER_1) && (l <= LAYER_4);
  endfunction

  // Words per part: W columns times the fixed number of rows per part.
  function automatic logic [9:0] layer_n(input logic [2:0] l);
    return layer_w(l) * 10'(RowsPerPart);
  endfunction

endpackage

`default_nettype wire

// File: rtl/output_read_fifo.sv
// ---------------------------------------------------------------------------
// output_read_fifo : shift-register skid FIFO, head entry is a register
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module output_read_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 129
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       pop_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       valid_o,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] w_up  [DEPTH];
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    w_count_d;
  logic [CW-1:0]    w_wr_idx;
  logic             valid_q;
  logic             w_pop;
  logic             w_push;

  // Entry i takes entry i+1 on a pop; the tail entry simply keeps its value.
  for (genvar i = 0; i < DEPTH; i++) begin : g_up
    if (i < DEPTH - 1) begin : g_mid
      assign w_up[i] = mem_q[i+1];
    end else begin : g_tail
      assign w_up[i] = mem_q[i];
    end
  end

  assign w_pop     = pop_i && (count_q != '0);
  assign w_push    = push_i && ((count_q != CW'(DEPTH)) || w_pop);
  assign w_wr_idx  = count_q - CW'(w_pop);
  assign w_count_d = count_q + CW'(w_push) - CW'(w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      count_q <= '0;
      valid_q <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (w_push && (w_wr_idx == CW'(i))) begin
          mem_q[i] <= din_i;
        end else if (w_pop) begin
          mem_q[i] <= w_up[i];
        end
      end
      count_q <= w_count_d;
      valid_q <= (w_count_d != '0);
    end
  end

  assign dout_o  = mem_q[0];
  assign valid_o = valid_q;
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/output_read.sv
// ---------------------------------------------------------------------------
// output_read : streams one ping-pong half of the output buffer as 128b beats
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module output_read
  import output_read_pkg::*;
#(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [2:0]              layer,
  input  logic                    half,
  output logic                    busy,
  output logic                    read_done,
  output logic                    en_rd,
  output logic [ADDR_WIDTH-1:0]   addr_rd,
  input  logic [DATA_WIDTH-1:0]   din_b0,
  input  logic [DATA_WIDTH-1:0]   din_b1,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [2*DATA_WIDTH-1:0] m_data,
  output logic                    m_last
);

  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int CWP = CW + 1;
  localparam int FW  = 2 * DATA_WIDTH + 1;

  rd_state_e      state_q;
  logic [2:0]     layer_q;
  logic           half_q;
  logic [9:0]     n_q;
  logic [9:0]     cnt_word_q;
  logic [1:0]     cnt_part_q;
  logic           read_done_q;
  logic           inflight_q;
  logic           last_inflight_q;

  logic [CW-1:0]  fifo_count;
  logic [FW-1:0]  fifo_dout;
  logic           fifo_valid;

  logic [CW:0]    w_occ;
  logic           w_issue;
  logic           w_word_end;
  logic           w_last;
  logic           w_pop;

  // Reads are issued only while the FIFO can absorb every outstanding word.
  assign w_occ      = {1'b0, fifo_count} + {{CW{1'b0}}, inflight_q};
  assign w_issue    = (state_q == S_READ) && (w_occ <= CWP'(FIFO_DEPTH - 2));
  assign w_word_end = (cnt_word_q == (n_q - 10'd1));
  assign w_last     = w_word_end && (cnt_part_q == 2'd3);
  assign w_pop      = fifo_valid && m_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      layer_q         <= 3'd0;
      half_q          <= 1'b0;
      n_q             <= 10'd0;
      cnt_word_q      <= 10'd0;
      cnt_part_q      <= 2'd0;
      read_done_q     <= 1'b0;
      inflight_q      <= 1'b0;
      last_inflight_q <= 1'b0;
    end else begin
      read_done_q     <= 1'b0;
      inflight_q      <= w_issue;
      last_inflight_q <= w_issue && w_last;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            layer_q <= layer;
            half_q  <= half;
            state_q <= S_CONFIG;
          end
        end
        S_CONFIG: begin
          cnt_word_q <= 10'd0;
          cnt_part_q <= 2'd0;
          if (layer_legal(layer_q)) begin
            n_q     <= layer_n(layer_q);
            state_q <= S_READ;
          end else begin
            read_done_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        S_READ: begin
          if (w_issue) begin
            if (w_word_end) begin
              cnt_word_q <= 10'd0;
              cnt_part_q <= cnt_part_q + 2'd1;
              if (cnt_part_q == 2'd3) begin
                state_q <= S_DRAIN;
              end
            end else begin
              cnt_word_q <= cnt_word_q + 10'd1;
            end
          end
        end
        S_DRAIN: begin
          // Completion is tied to the tagged final beat leaving the FIFO.
          if (w_pop && m_last) begin
            read_done_q <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  output_read_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (FW)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (inflight_q),
    .din_i   ({last_inflight_q, din_b1, din_b0}),
    .pop_i   (m_ready),
    .dout_o  (fifo_dout),
    .valid_o (fifo_valid),
    .count_o (fifo_count)
  );

  // Half, part and word fields are power-of-two aligned, so the sum is a concat.
  assign addr_rd   = ADDR_WIDTH'({half_q, cnt_part_q, cnt_word_q});
  assign en_rd     = w_issue;
  assign busy      = (state_q != S_IDLE);
  assign read_done = read_done_q;
  assign m_valid   = fifo_valid;
  assign m_data    = fifo_dout[2*DATA_WIDTH-1:0];
  assign m_last    = fifo_dout[FW-1];

endmodule

`default_nettype wire

// File: tb/tb_output_read.sv
// ---------------------------------------------------------------------------
// tb_output_read : table-driven directed bench for output_read
// Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_output_read;

  localparam int AW = 13;
  localparam int DW = 64;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    layer = 3'd0;
  logic          half = 1'b0;
  logic          m_ready = 1'b0;
  logic          busy, read_done, en_rd, m_valid, m_last;
  logic [AW-1:0] addr_rd;
  logic [DW-1:0] din_b0 = '0;
  logic [DW-1:0] din_b1 = '0;
  logic [2*DW-1:0] m_data;

  output_read #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .layer(layer), .half(half),
    .busy(busy), .read_done(read_done), .en_rd(en_rd), .addr_rd(addr_rd),
    .din_b0(din_b0), .din_b1(din_b1), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] b0f(input logic [12:0] a);
    return 64'hB000_0000_0000_0000 | {51'd0, a};
  endfunction

  function automatic logic [63:0] b1f(input logic [12:0] a);
    return 64'hC100_0000_0000_0000 | {31'd0, a, 20'd0};
  endfunction

  // Bank model: one cycle of read latency.
  always @(posedge clk) begin
    if (en_rd) begin
      din_b0 <= b0f(addr_rd);
      din_b1 <= b1f(addr_rd);
    end
  end

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic check_idle(input string pfx);
    check({pfx, " busy"}, busy, 0);
    check({pfx, " read_done"}, read_done, 0);
    check({pfx, " en_rd"}, en_rd, 0);
    check({pfx, " addr_rd"}, addr_rd, 0);
    check({pfx, " m_valid"}, m_valid, 0);
    check({pfx, " m_data_zero"}, (m_data == '0), 1);
    check({pfx, " m_last"}, m_last, 0);
  endtask

  function automatic int n_of(input int l);
    case (l)
      1: return 714;
      2: return 354;
      3: return 174;
      4: return 84;
      default: return 0;
    endcase
  endfunction

  function automatic logic [12:0] exp_addr(input int h, input int n, input int k);
    int v;
    if (n == 0) return 13'd0;
    v = h * 4096 + (k / n) * 1024 + (k % n);
    return v[12:0];
  endfunction

  int s_beats, s_first_valid, s_first_en, s_done_cyc, s_last_hs, s_en_cnt;
  int s_order_err, s_addr_err, s_stable_err, s_last_err, s_max_out;
  int s_first_addr, s_last_addr, s_en_stall;

  // mode 0: ready always high; 1: random ready; 2: ready low for 20 cycles after first read
  task automatic run(input int l, input int h, input int mode, input int restart);
    int n, cyc, budget, occ;
    logic got_done, pv_stall, plast;
    logic [2*DW-1:0] pdata;
    logic [12:0] a;
    n = n_of(l);
    s_beats = 0; s_first_valid = -1; s_first_en = -1; s_done_cyc = -1; s_last_hs = -1;
    s_en_cnt = 0; s_order_err = 0; s_addr_err = 0; s_stable_err = 0; s_last_err = 0;
    s_max_out = 0; s_first_addr = -1; s_last_addr = -1; s_en_stall = 0;
    @(negedge clk);
    layer = 3'(l); half = h[0]; start = 1'b1; m_ready = 1'b1;
    cyc = 0; budget = 8 * 4 * n + 100; got_done = 1'b0; pv_stall = 1'b0; pdata = '0; plast = 1'b0;
    while (!got_done && cyc < budget) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart);
      layer = (cyc == restart) ? 3'd1 : 3'd7;
      half  = ~h[0];
      if (read_done) begin
        got_done = 1'b1;
        s_done_cyc = cyc;
      end
      occ = s_en_cnt - s_beats;
      if (occ > s_max_out) s_max_out = occ;
      if (en_rd) begin
        if (s_first_en < 0) s_first_en = cyc;
        if (addr_rd != exp_addr(h, n, s_en_cnt)) s_addr_err++;
        s_en_cnt++;
      end
      if (mode == 2 && s_first_en >= 0 && cyc <= s_first_en + 20) s_en_stall = s_en_cnt;
      if (pv_stall && (!m_valid || m_data != pdata || m_last != plast)) s_stable_err++;
      if (m_valid && s_first_valid < 0) s_first_valid = cyc;
      case (mode)
        1:       m_ready = 1'($urandom_range(0, 1));
        2:       m_ready = !(s_first_en >= 0 && cyc <= s_first_en + 20);
        default: m_ready = 1'b1;
      endcase
      if (m_valid && m_ready) begin
        a = exp_addr(h, n, s_beats);
        if (s_beats >= 4 * n || m_data != {b1f(a), b0f(a)}) s_order_err++;
        if (m_last != (s_beats == 4 * n - 1)) s_last_err++;
        if (s_first_addr < 0) s_first_addr = int'(m_data[12:0]);
        s_last_addr = int'(m_data[12:0]);
        s_beats++;
        s_last_hs = cyc;
      end
      pv_stall = m_valid && !m_ready;
      pdata = m_data;
      plast = m_last;
    end
    start = 1'b0;
    check($sformatf("L%0d read_done seen", l), got_done, 1);
  endtask

  typedef struct {
    int layer; int half; int mode; int restart;
    int beats; int first_addr; int last_addr;
    int first_valid; int first_en; int done_cyc;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int found;
    tbl[0] = '{4, 0, 0, -1,  336,    0, 3155,  4,  2, -1};
    tbl[1] = '{1, 1, 1, -1, 2856, 4096, 7881,  4,  2, -1};
    tbl[2] = '{3, 0, 2, -1,  696,    0, 3245,  4,  2, -1};
    tbl[3] = '{0, 0, 0, -1,    0,    0,    0, -1, -1,  2};
    tbl[4] = '{6, 1, 0, -1,    0,    0,    0, -1, -1,  2};
    tbl[5] = '{4, 1, 1, 40,  336, 4096, 7251,  4,  2, -1};
    tbl[6] = '{2, 1, 0, -1, 1416, 4096, 7521,  4,  2, -1};

    #12;
    check_idle("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run(tbl[i].layer, tbl[i].half, tbl[i].mode, tbl[i].restart);
      check($sformatf("v%0d beats", i), s_beats, tbl[i].beats);
      check($sformatf("v%0d read addr order", i), s_addr_err, 0);
      check($sformatf("v%0d beat data/order", i), s_order_err, 0);
      check($sformatf("v%0d stall stability", i), s_stable_err, 0);
      check($sformatf("v%0d m_last placement", i), s_last_err, 0);
      check($sformatf("v%0d occupancy<=4", i), (s_max_out <= 4), 1);
      check($sformatf("v%0d first m_valid cycle", i), s_first_valid, tbl[i].first_valid);
      check($sformatf("v%0d first en_rd cycle", i), s_first_en, tbl[i].first_en);
      if (tbl[i].done_cyc >= 0)
        check($sformatf("v%0d read_done cycle", i), s_done_cyc, tbl[i].done_cyc);
      else
        check($sformatf("v%0d read_done after last", i), s_done_cyc, s_last_hs + 1);
      if (tbl[i].beats > 0) begin
        check($sformatf("v%0d first addr", i), s_first_addr, tbl[i].first_addr);
        check($sformatf("v%0d last addr", i), s_last_addr, tbl[i].last_addr);
      end
      if (tbl[i].mode == 2)
        check($sformatf("v%0d reads during stall<=4", i), (s_en_stall <= 4), 1);
    end

    // Abort in part 2 of a layer-2 transfer with an asynchronous reset.
    @(negedge clk);
    layer = 3'd2; half = 1'b0; start = 1'b1; m_ready = 1'b1;
    found = 0;
    for (int c = 0; c < 3000 && found == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (en_rd && addr_rd == 13'd2098) found = 1;
    end
    check("arst reached part 2", found, 1);
    #2 rst_n = 1'b0;
    #1 check_idle("arst");
    @(negedge clk);
    check("arst no read_done", read_done, 0);
    rst_n = 1'b1;
    run(2, 0, 0, -1);
    check("replay beats", s_beats, 1416);
    check("replay first addr", s_first_addr, 0);
    check("replay last addr", s_last_addr, 3425);
    check("replay order", s_order_err + s_addr_err + s_last_err, 0);
    check("replay first en cycle", s_first_en, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
